// File: rtl/step_accum.sv
// step_accum: CHANNELS independent WIDTH-bit counters driven by INC/ADD/LOAD/CLEAR
// commands over a valid/ready input. Each accepted command returns the channel's
// new value through a single registered valid/ready output stage.
module step_accum #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_cmd,
  input  logic [CH_W-1:0] in_ch,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic            out_ovf,
  output logic            out_err
);

  localparam logic [1:0] CMD_INC  = 2'b00;
  localparam logic [1:0] CMD_ADD  = 2'b01;
  localparam logic [1:0] CMD_LOAD = 2'b10;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Returns {ovf, result}: wrap keeps the carry as ovf, saturate clamps to all-ones.
  function automatic logic [WIDTH:0] add_ws(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if ((SATURATE != 0) && sum[WIDTH])
      return {1'b1, {WIDTH{1'b1}}};
    return sum;
  endfunction

  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] cur_p0;
  logic [WIDTH-1:0] res_p0;
  logic             ovf_p0;
  logic             ch_ok_p0;
  logic             accept;

  // Ready whenever the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage p0: select the addressed counter and compute the command result.
  always_comb begin
    cur_p0   = '0;
    res_p0   = '0;
    ovf_p0   = 1'b0;
    ch_ok_p0 = ({1'b0, in_ch} < (CH_W + 1)'(CHANNELS));
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i))
        cur_p0 = cnt[i];
    end
    case (in_cmd)
      CMD_INC:  {ovf_p0, res_p0} = add_ws(cur_p0, STEP_W);
      CMD_ADD:  {ovf_p0, res_p0} = add_ws(cur_p0, in_data);
      CMD_LOAD: res_p0 = in_data;
      default:  res_p0 = '0;
    endcase
    if (!ch_ok_p0) begin
      res_p0 = '0;
      ovf_p0 = 1'b0;
    end
  end

  // Counter bank: write the result back into the addressed channel on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= '0;
    end else if (accept && ch_ok_p0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_ch == CH_W'(i))
          cnt[i] <= res_p0;
      end
    end
  end

  // Stage p1: output register, loaded on accept, emptied on drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= res_p0;
      out_ovf   <= ovf_p0;
      out_err   <= !ch_ok_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_accum.sv
// Bench for step_accum: three instances with different parameter sets, a
// directed vector table, hand-written backpressure/reset sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_step_accum;

  // Instance parameters: 0 = default, 1 = STEP 7 / 3 channels, 2 = 4-bit saturating.
  localparam int W   [3] = '{8, 8, 4};
  localparam int S   [3] = '{1, 7, 1};
  localparam int C   [3] = '{2, 3, 2};
  localparam int SAT [3] = '{0, 0, 1};
  localparam int CHW [3] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]      iv, ordy;
  logic [2:0][1:0] icmd, ich;
  logic [2:0][7:0] idat;
  logic [2:0]      ir, ov, oovf, oerr;
  logic [2:0][7:0] od;
  logic [2:0][1:0] och;

  logic [0:0] och0_n, och2_n;
  logic [1:0] och1_n;
  logic [7:0] od0_n, od1_n;
  logic [3:0] od2_n;

  always #5 clk = ~clk;

  step_accum #(.WIDTH(8), .STEP(1), .CHANNELS(2), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_cmd(icmd[0]),
    .in_ch(ich[0][0:0]), .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_ch(och0_n), .out_data(od0_n), .out_ovf(oovf[0]), .out_err(oerr[0]));

  step_accum #(.WIDTH(8), .STEP(7), .CHANNELS(3), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_cmd(icmd[1]),
    .in_ch(ich[1]), .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_ch(och1_n), .out_data(od1_n), .out_ovf(oovf[1]), .out_err(oerr[1]));

  step_accum #(.WIDTH(4), .STEP(1), .CHANNELS(2), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_cmd(icmd[2]),
    .in_ch(ich[2][0:0]), .in_data(idat[2][3:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_ch(och2_n), .out_data(od2_n), .out_ovf(oovf[2]), .out_err(oerr[2]));

  assign och[0] = {1'b0, och0_n};
  assign och[1] = och1_n;
  assign och[2] = {1'b0, och2_n};
  assign od[0]  = od0_n;
  assign od[1]  = od1_n;
  assign od[2]  = {4'h0, od2_n};

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int cnt_m [3][4];
  bit ev [3];
  int ed [3], ech [3], eovf [3], eerr [3];

  typedef struct {
    int d; int c; int ch; int data;
    int e_data; int e_ovf; int e_err;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) cnt_m[d][c] = 0;
      ev[d] = 0; ed[d] = 0; ech[d] = 0; eovf[d] = 0; eerr[d] = 0;
    end
  endfunction

  // Applies one accepted command to instance d using plain integer arithmetic.
  function automatic void model_apply(input int d, input int c, input int ch, input int data);
    int maxv, chs, dat, sum, res, o, e;
    maxv = (1 << W[d]) - 1;
    chs  = ch % (1 << CHW[d]);
    dat  = data % (maxv + 1);
    res = 0; o = 0; e = 0;
    if (chs >= C[d]) begin
      e = 1;
    end else begin
      case (c)
        0, 1: begin
          sum = cnt_m[d][chs] + ((c == 0) ? (S[d] % (maxv + 1)) : dat);
          if (sum > maxv) begin
            o = 1;
            res = (SAT[d] != 0) ? maxv : sum - (maxv + 1);
          end else begin
            res = sum;
          end
        end
        2: res = dat;
        default: res = 0;
      endcase
      cnt_m[d][chs] = res;
    end
    ev[d] = 1; ed[d] = res; ech[d] = chs; eovf[d] = o; eerr[d] = e;
  endfunction

  task automatic check_out(input int d);
    chk($sformatf("valid%0d", d), int'(ov[d]), int'(ev[d]));
    if (ev[d]) begin
      chk($sformatf("data%0d", d), int'(od[d]), ed[d]);
      chk($sformatf("ch%0d", d), int'(och[d]), ech[d]);
      chk($sformatf("ovf%0d", d), int'(oovf[d]), eovf[d]);
      chk($sformatf("err%0d", d), int'(oerr[d]), eerr[d]);
    end
  endtask

  // Called at a negedge: presents one command with out_ready high, checks the result.
  task automatic do_cmd(input int d, input int c, input int ch, input int data);
    icmd[d] = 2'(c); ich[d] = 2'(ch); idat[d] = 8'(data);
    iv[d] = 1'b1; ordy[d] = 1'b1;
    #1 chk($sformatf("in_ready%0d", d), int'(ir[d]), 1);
    @(posedge clk); @(negedge clk);
    iv[d] = 1'b0;
    model_apply(d, c, ch, data);
    check_out(d);
  endtask

  task automatic run_random(input int d, input int ncyc);
    bit acc;
    for (int n = 0; n < ncyc; n++) begin
      if (!iv[d] && $urandom_range(0, 3) != 0) begin
        icmd[d] = 2'($urandom_range(0, 3));
        ich[d]  = 2'($urandom_range(0, 3));
        idat[d] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom);
        iv[d]   = 1'b1;
      end
      ordy[d] = ($urandom_range(0, 3) != 0);
      #1 chk($sformatf("rnd_ready%0d", d), int'(ir[d]), int'(!ev[d] || ordy[d]));
      acc = iv[d] && (!ev[d] || ordy[d]);
      @(posedge clk); @(negedge clk);
      if (acc) begin
        model_apply(d, int'(icmd[d]), int'(ich[d]), int'(idat[d]));
        iv[d] = 1'b0;
      end else if (ordy[d]) begin
        ev[d] = 0;
      end
      check_out(d);
    end
    iv[d] = 1'b0; ordy[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    ev[d] = 0;
    check_out(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; iv = '0; ordy = '1; icmd = '0; ich = '0; idat = '0;
    model_reset();

    tbl.push_back(vec_t'{0, 0, 0, 0,     1,    0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0,     2,    0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0,     3,    0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0,     1,    0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 'h55,  2,    0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 'hFF,  1,    1, 0});
    tbl.push_back(vec_t'{1, 2, 1, 'hFC,  'hFC, 0, 0});
    tbl.push_back(vec_t'{1, 0, 1, 0,     'h03, 1, 0});
    tbl.push_back(vec_t'{2, 2, 0, 'hD,   'hD,  0, 0});
    tbl.push_back(vec_t'{2, 1, 0, 5,     'hF,  1, 0});
    tbl.push_back(vec_t'{2, 1, 0, 0,     'hF,  0, 0});
    tbl.push_back(vec_t'{2, 2, 1, 'hE,   'hE,  0, 0});
    tbl.push_back(vec_t'{2, 1, 1, 3,     'hF,  1, 0});
    tbl.push_back(vec_t'{1, 0, 3, 0,     0,    0, 1});
    tbl.push_back(vec_t'{1, 1, 0, 0,     0,    0, 0});
    tbl.push_back(vec_t'{1, 1, 1, 0,     3,    0, 0});
    tbl.push_back(vec_t'{1, 1, 2, 0,     0,    0, 0});
    tbl.push_back(vec_t'{1, 3, 1, 'hAA,  0,    0, 0});
    tbl.push_back(vec_t'{1, 2, 2, 'hFF,  'hFF, 0, 0});
    tbl.push_back(vec_t'{1, 1, 2, 1,     0,    1, 0});

    // Reset state, while held and on the first cycle after release.
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), int'(ov[d]), 0);
      chk($sformatf("rst_data%0d", d), int'(od[d]), 0);
      chk($sformatf("rst_ch%0d", d), int'(och[d]), 0);
      chk($sformatf("rst_ovf%0d", d), int'(oovf[d]), 0);
      chk($sformatf("rst_err%0d", d), int'(oerr[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rel_ready%0d", d), int'(ir[d]), 1);
      chk($sformatf("rel_valid%0d", d), int'(ov[d]), 0);
    end

    // Directed vectors, back-to-back.
    foreach (tbl[k]) begin
      do_cmd(tbl[k].d, tbl[k].c, tbl[k].ch, tbl[k].data);
      chk($sformatf("tbl%0d_data", k), int'(od[tbl[k].d]), tbl[k].e_data);
      chk($sformatf("tbl%0d_ovf", k), int'(oovf[tbl[k].d]), tbl[k].e_ovf);
      chk($sformatf("tbl%0d_err", k), int'(oerr[tbl[k].d]), tbl[k].e_err);
    end

    // Backpressure on instance 0: ch0 holds 3 here.
    do_cmd(0, 0, 0, 0);
    chk("bp_first", int'(od[0]), 4);
    ordy[0] = 1'b0;
    icmd[0] = 2'd0; ich[0] = 2'd0; idat[0] = 8'd0; iv[0] = 1'b1;
    #1 chk("bp_ready_low", int'(ir[0]), 0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_ready_held", int'(ir[0]), 0);
      chk("bp_valid_held", int'(ov[0]), 1);
      chk("bp_data_held", int'(od[0]), 4);
    end
    ordy[0] = 1'b1;
    #1 chk("bp_ready_back", int'(ir[0]), 1);
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    model_apply(0, 0, 0, 0);
    check_out(0);
    chk("bp_second", int'(od[0]), 5);
    do_cmd(0, 1, 0, 0);
    chk("bp_readback", int'(od[0]), 5);
    @(posedge clk); @(negedge clk);
    ev[0] = 0;
    chk("bp_drained", int'(ov[0]), 0);

    // Asynchronous reset in the middle of a stream.
    icmd[0] = 2'd0; ich[0] = 2'd0; iv[0] = 1'b1; ordy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("ar_valid_before", int'(ov[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("ar_valid_drop", int'(ov[0]), 0);
    chk("ar_data_drop", int'(od[0]), 0);
    iv[0] = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(0, 0, 0, 0);
    chk("ar_inc_after", int'(od[0]), 1);

    // Randomized traffic with random backpressure on each instance.
    for (int d = 0; d < 3; d++) run_random(d, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
